fast_keypoint_detection_divmod_22ns_11ns_seq: RTL

Sequential unsigned divider: the inverse of the 11x11 row*width multiplier used for pixel addressing. It splits a linear pixel address back into (row, col) = (addr / width, addr % width) for keypoint coordinate output. It uses a radix-2 restoring algorithm with one quotient bit per cycle and valid/ready handshakes on both sides. It sits between the keypoint address FIFO and the coordinate packer.

---
 rtl/fast_keypoint_detection_divmod_22ns_11ns_seq_pkg.sv | 15 +
 rtl/fast_keypoint_detection_divmod_22ns_11ns_seq_if.sv | 28 ++
 rtl/fast_keypoint_detection_divmod_step.sv | 24 ++
 rtl/fast_keypoint_detection_divmod_22ns_11ns_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fast_keypoint_detection_divmod_22ns_11ns_seq_pkg.sv
// Shared constants and FSM encoding for the keypoint address divider.
// The divider splits a linear pixel address into (row, col).
package fast_keypoint_detection_divmod_22ns_11ns_seq_pkg;

    localparam int DEF_DIVIDEND_WIDTH = 22;
    localparam int DEF_DIVISOR_WIDTH  = 11;
    localparam int CNT_WIDTH          = $clog2(DEF_DIVIDEND_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/fast_keypoint_detection_divmod_22ns_11ns_seq_if.sv
// Operand and result handshake bundle for the keypoint address divider.
// The slave side is the divider; the master side is the producer and consumer pair.
interface fast_keypoint_detection_divmod_22ns_11ns_seq_if
    import fast_keypoint_detection_divmod_22ns_11ns_seq_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DIVIDEND_WIDTH-1:0] in_dividend;
    logic [DIVISOR_WIDTH-1:0]  in_divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIVIDEND_WIDTH-1:0] out_quotient;
    logic [DIVISOR_WIDTH-1:0]  out_remainder;
    logic                      out_div_by_zero;

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero
    );

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero
    );
endinterface

// File: rtl/fast_keypoint_detection_divmod_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not borrow.
module fast_keypoint_detection_divmod_step
    import fast_keypoint_detection_divmod_22ns_11ns_seq_pkg::*;
#(
    parameter int DIVISOR_WIDTH = DEF_DIVISOR_WIDTH
) (
    input  logic [DIVISOR_WIDTH:0]   rem,
    input  logic                     dividend_msb,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic [DIVISOR_WIDTH:0]   rem_next,
    output logic                     q_bit
);
    // One spare bit above the shifted remainder so the borrow is an explicit sign bit.
    logic [DIVISOR_WIDTH+1:0] shifted;
    logic [DIVISOR_WIDTH+1:0] trial;

    always_comb begin
        shifted  = {rem, dividend_msb};
        trial    = shifted - {2'b00, divisor};
        q_bit    = ~trial[DIVISOR_WIDTH+1];
        rem_next = q_bit ? trial[DIVISOR_WIDTH:0] : shifted[DIVISOR_WIDTH:0];
    end
endmodule

// File: rtl/fast_keypoint_detection_divmod_22ns_11ns_seq.sv
// Sequential unsigned divider: linear pixel address / image width -> (row, col),
// one quotient bit per cycle, valid/ready on both sides, no overlap between operations.
module fast_keypoint_detection_divmod_22ns_11ns_seq
    import fast_keypoint_detection_divmod_22ns_11ns_seq_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) (
    input logic ap_clk,
    input logic ap_rst,
    fast_keypoint_detection_divmod_22ns_11ns_seq_if.slave bus
);
    localparam int CW = $clog2(DIVIDEND_WIDTH);

    div_state_e                state_q, state_d;
    logic [CW-1:0]             cnt_q;
    logic [DIVIDEND_WIDTH-1:0] dvd_q;
    logic [DIVISOR_WIDTH-1:0]  dsr_q;
    logic [DIVISOR_WIDTH-1:0]  dvd_low_q;
    logic [DIVISOR_WIDTH:0]    rem_q;
    logic [DIVIDEND_WIDTH-1:0] quot_q;
    logic [DIVISOR_WIDTH-1:0]  remd_q;
    logic                      dz_q;

    logic [DIVISOR_WIDTH:0]    rem_next;
    logic                      q_bit;
    logic                      in_ready;
    logic                      out_valid;
    logic                      last_iter;

    assign last_iter = (cnt_q == '0);

    fast_keypoint_detection_divmod_step #(
        .DIVISOR_WIDTH (DIVISOR_WIDTH)
    ) u_step (
        .rem          (rem_q),
        .dividend_msb (dvd_q[DIVIDEND_WIDTH-1]),
        .divisor      (dsr_q),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (last_iter) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            dvd_low_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            remd_q    <= '0;
            dz_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        dvd_q     <= bus.in_dividend;
                        dsr_q     <= bus.in_divisor;
                        dvd_low_q <= bus.in_dividend[DIVISOR_WIDTH-1:0];
                        rem_q     <= '0;
                        cnt_q     <= CW'(DIVIDEND_WIDTH - 1);
                    end
                end
                ST_BUSY: begin
                    // Quotient bits shift in at the bottom as dividend bits leave the top.
                    dvd_q <= {dvd_q[DIVIDEND_WIDTH-2:0], q_bit};
                    rem_q <= rem_next;
                    if (!last_iter) cnt_q <= cnt_q - 1'b1;
                    if (last_iter) begin
                        if (dsr_q == '0) begin
                            quot_q <= '1;
                            remd_q <= dvd_low_q;
                            dz_q   <= 1'b1;
                        end else begin
                            quot_q <= {dvd_q[DIVIDEND_WIDTH-2:0], q_bit};
                            remd_q <= rem_next[DIVISOR_WIDTH-1:0];
                            dz_q   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.out_valid       = out_valid;
    assign bus.out_quotient    = quot_q;
    assign bus.out_remainder   = remd_q;
    assign bus.out_div_by_zero = dz_q;
endmodule
